// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-bank responder: N_REGS word registers with byte-strobed writes,
// independent AW/W capture, SLVERR on out-of-range, unaligned or secure-violating access.
module axi_lite_reg_slave #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            N_REGS      = 16,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
  parameter logic [N_REGS-1:0]      SECURE_MASK = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr_i,
  input  logic [2:0]                     awprot_i,
  input  logic                           awvalid_i,
  output logic                           awready_o,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic [1:0]                     bresp_o,
  output logic                           bvalid_o,
  input  logic                           bready_i,
  input  logic [ADDR_WIDTH-1:0]          araddr_i,
  input  logic [2:0]                     arprot_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  output logic [N_REGS*DATA_WIDTH-1:0]   regs_o,
  output logic [N_REGS-1:0]              wr_pulse_o
);

  localparam int unsigned           BYTES       = DATA_WIDTH / 8;
  localparam int unsigned           OFF_LSB     = $clog2(BYTES);
  localparam int unsigned           IDX_W       = $clog2(N_REGS);
  localparam logic [ADDR_WIDTH:0]   SPAN        = (ADDR_WIDTH+1)'(N_REGS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(BYTES - 1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic             err;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // One extra bit on the subtraction makes addr < BASE_ADDR land above SPAN.
  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr, input logic nonsec);
    logic [ADDR_WIDTH:0] off;
    dec_t d;
    off   = {1'b0, addr} - {1'b0, BASE_ADDR};
    d.idx = IDX_W'(off >> OFF_LSB);
    d.err = (off >= SPAN) || ((off[ADDR_WIDTH-1:0] & ALIGN_MASK) != '0);
    if (!d.err && SECURE_MASK[d.idx] && nonsec) d.err = 1'b1;
    return d;
  endfunction

  logic [DATA_WIDTH-1:0] regs [N_REGS];
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_nonsec;
  logic                  aw_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [BYTES-1:0]      w_strb;
  logic                  w_full;
  dec_t                  wr_dec_c;
  dec_t                  rd_dec_c;
  logic                  unused_prot;

  assign unused_prot = ^{awprot_i[2], awprot_i[0], arprot_i[2], arprot_i[0]};

  assign awready_o = !aw_full && !bvalid_o;
  assign wready_o  = !w_full && !bvalid_o;
  assign arready_o = !rvalid_o;

  always_comb begin
    wr_dec_c = decode(aw_addr, aw_nonsec);
    rd_dec_c = decode(araddr_i, arprot_i[1]);
  end

  // Write path: capture AW and W independently, commit once both are held.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_addr    <= '0;
      aw_nonsec  <= 1'b0;
      aw_full    <= 1'b0;
      w_data     <= '0;
      w_strb     <= '0;
      w_full     <= 1'b0;
      bvalid_o   <= 1'b0;
      bresp_o    <= RESP_OKAY;
      wr_pulse_o <= '0;
      for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (awvalid_i && awready_o) begin
        aw_addr   <= awaddr_i;
        aw_nonsec <= awprot_i[1];
        aw_full   <= 1'b1;
      end
      if (wvalid_i && wready_o) begin
        w_data <= wdata_i;
        w_strb <= wstrb_i;
        w_full <= 1'b1;
      end
      if (aw_full && w_full) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_o <= 1'b1;
        if (wr_dec_c.err) begin
          bresp_o <= RESP_SLVERR;
        end else begin
          bresp_o <= RESP_OKAY;
          wr_pulse_o[wr_dec_c.idx] <= 1'b1;
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (w_strb[k]) regs[wr_dec_c.idx][8*k +: 8] <= w_data[8*k +: 8];
          end
        end
      end else if (bvalid_o && bready_i) begin
        bvalid_o <= 1'b0;
      end
    end
  end

  // Read path: AR accepted only while no R beat is pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rresp_o  <= RESP_OKAY;
    end else if (arvalid_i && arready_o) begin
      rvalid_o <= 1'b1;
      if (rd_dec_c.err) begin
        rdata_o <= '0;
        rresp_o <= RESP_SLVERR;
      end else begin
        rdata_o <= regs[rd_dec_c.idx];
        rresp_o <= RESP_OKAY;
      end
    end else if (rvalid_o && rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
